// File: rtl/rr_grant_scheduler.sv
// Purpose : round-robin owner of a shared single-owner resource; holds the grant
//           across a multi-cycle transaction and advances the pointer on release.
// Latency : grant registered 1 cycle after the sampled request; >=1 idle cycle between owners.
// Backpr. : no backpressure; the owner keeps the grant until done, request drop or MAX_HOLD.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req[i]       requester i wants the resource
//   done[i]      requester i ends its transaction (only the current owner's bit matters)
//   grant        registered one-hot grant, zero when there is no owner
//   grant_valid  registered, high while an owner exists
//   grant_idx    registered owner index, 0 when no owner
//   preempt      one-cycle pulse after a release forced by the hold limit
//   ptr          highest-priority index at the next arbitration

// Combinational round-robin pick: lowest requesting index >= state, else the
// lowest requesting index overall. Purely combinational, no backpressure.
module round_robin_arbiter #(
    parameter int INPUTS = 4
) (
    input  logic [INPUTS-1:0]         req,
    input  logic [$clog2(INPUTS)-1:0] state,
    output logic [INPUTS-1:0]         gnt,
    output logic [$clog2(INPUTS)-1:0] gnt_idx,
    output logic                      gnt_vld
);
    localparam int IDX_W = $clog2(INPUTS);

    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] hi_idx;
    logic             hi_vld;

    always_comb begin
        lo_idx  = '0;
        hi_idx  = '0;
        hi_vld  = 1'b0;
        gnt_vld = 1'b0;
        // Scanning downwards lets the last hit be the lowest index in each class.
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx  = IDX_W'(i);
                gnt_vld = 1'b1;
                if (i >= int'(state)) begin
                    hi_idx = IDX_W'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        gnt_idx = hi_vld ? hi_idx : lo_idx;
        gnt     = '0;
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end
endmodule

module rr_grant_scheduler #(
    parameter int INPUTS   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INPUTS-1:0]         req,
    input  logic [INPUTS-1:0]         done,
    output logic [INPUTS-1:0]         grant,
    output logic                      grant_valid,
    output logic [$clog2(INPUTS)-1:0] grant_idx,
    output logic                      preempt,
    output logic [$clog2(INPUTS)-1:0] ptr
);
    localparam int IDX_W = $clog2(INPUTS);
    localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [INPUTS-1:0]   grant_q, grant_d;
    logic                grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic                preempt_q, preempt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [INPUTS-1:0]   arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;

    logic                rel_done;
    logic                rel_drop;
    logic                rel_hold;

    round_robin_arbiter #(
        .INPUTS (INPUTS)
    ) u_arb (
        .req     (req),
        .state   (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        preempt_d     = 1'b0;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;

        rel_done = done[grant_idx_q];
        rel_drop = ~req[grant_idx_q];
        rel_hold = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_d       = arb_gnt;
                    grant_idx_d   = arb_idx;
                    grant_valid_d = 1'b1;
                    cnt_d         = CNT_W'(1);
                    state_d       = OWNED;
                end
            end
            OWNED: begin
                if (rel_done || rel_drop || rel_hold) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_idx_d   = '0;
                    cnt_d         = '0;
                    state_d       = IDLE;
                    // Explicit wrap so non-power-of-two INPUTS rotate correctly.
                    ptr_d         = (grant_idx_q == IDX_W'(INPUTS - 1)) ? '0
                                                                        : grant_idx_q + IDX_W'(1);
                    // A voluntary end on the same edge wins over the hold limit.
                    preempt_d     = rel_hold && !rel_done && !rel_drop;
                end else if ((MAX_HOLD != 0) && (cnt_q != CNT_W'(MAX_HOLD))) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            preempt_q     <= 1'b0;
            ptr_q         <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            preempt_q     <= preempt_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign preempt     = preempt_q;
    assign ptr         = ptr_q;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
module tb_rr_grant_scheduler;
    localparam int N   = 4;
    localparam int MH  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         preempt;
    logic [1:0]   ptr;

    int n_cmp = 0;
    int n_err = 0;

    rr_grant_scheduler #(
        .INPUTS   (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .preempt     (preempt),
        .ptr         (ptr)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // owner = -1 when the resource is free; held = cycles owned so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_pre   = 0;
    bit m_init  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_pre   = 0;
            m_init  = 1;
        end else if (m_owner < 0) begin
            m_pre = 0;
            // Walk the ring starting at ptr; first requester wins.
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else begin
            bit d, dr, t;
            d  = done[m_owner];
            dr = !req[m_owner];
            t  = (MH != 0) && (m_held >= MH);
            if (d || dr || t) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_held  = 0;
                m_pre   = t && !d && !dr;
            end else begin
                m_held = m_held + 1;
                m_pre  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            logic [N-1:0] eg;
            logic [1:0]   ei;
            logic         ev;
            eg = '0;
            ei = '0;
            ev = 1'b0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                ei = 2'(m_owner);
                ev = 1'b1;
            end
            n_cmp++;
            if (grant !== eg || grant_valid !== ev || grant_idx !== ei ||
                preempt !== m_pre || ptr !== 2'(m_ptr)) begin
                n_err++;
                $display("FAIL model_cmp t=%0t got g=%b v=%b i=%0d p=%b ptr=%0d, want g=%b v=%b i=%0d p=%b ptr=%0d",
                         $time, grant, grant_valid, grant_idx, preempt, ptr,
                         eg, ev, ei, m_pre, m_ptr);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] pat_req  [8] = '{4'b1111, 4'b0101, 4'b1010, 4'b1100, 4'b0011, 4'b1000, 4'b0110, 4'b1111};
    logic [N-1:0] pat_done [8] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1001, 4'b0000, 4'b0010, 4'b0000};

    initial begin
        logic [N-1:0] eg;
        rst  = 1'b1;
        req  = 4'b1111;
        done = 4'b0000;

        // Reset held for two edges with all requests up.
        cyc(); cyc();
        check("rst_grant", int'(grant), 0);
        check("rst_valid", int'(grant_valid), 0);
        check("rst_ptr", int'(ptr), 0);
        check("rst_preempt", int'(preempt), 0);
        rst = 1'b0;
        cyc();
        check("first_grant", int'(grant), 4'b0001);

        // Rotation: each owner ends after its second grant cycle.
        for (int k = 1; k <= 4; k++) begin
            eg = '0;
            eg[(k - 1) % 4] = 1'b1;
            check("rot_grant_c1", int'(grant), int'(eg));
            cyc();
            check("rot_grant_c2", int'(grant), int'(eg));
            done = eg;
            cyc();
            done = '0;
            check("rot_gap", int'(grant), 0);
            check("rot_ptr", int'(ptr), k % 4);
            cyc();
        end
        check("rot_wrap_grant", int'(grant), 4'b0001);

        // Skipping and wrap: release owner 0 then owner 1 to get ptr=2.
        done = 4'b0001;
        cyc();
        done = '0;
        cyc();
        check("skip_owner1", int'(grant), 4'b0010);
        done = 4'b0010;
        cyc();
        done = '0;
        check("skip_ptr2", int'(ptr), 2);
        req = 4'b0011;
        cyc();
        check("skip_wrap_grant", int'(grant), 4'b0001);
        check("skip_ptr_stable", int'(ptr), 2);
        done = 4'b0001;
        cyc();
        done = '0;
        check("skip_ptr1", int'(ptr), 1);
        req = 4'b1001;
        cyc();
        check("skip_grant3", int'(grant), 4'b1000);
        req = 4'b0000;
        cyc();
        check("drop_release", int'(grant), 0);
        check("drop_ptr_wrap", int'(ptr), 0);

        // Timeout at MAX_HOLD=4.
        req = 4'b0010;
        cyc();
        for (int c = 1; c <= MH; c++) begin
            check("hold_grant", int'(grant), 4'b0010);
            check("hold_no_pre", int'(preempt), 0);
            if (c < MH) cyc();
        end
        cyc();
        check("timeout_grant", int'(grant), 0);
        check("timeout_preempt", int'(preempt), 1);
        check("timeout_ptr", int'(ptr), 2);
        cyc();
        check("regrant", int'(grant), 4'b0010);
        check("regrant_pre_clr", int'(preempt), 0);

        // done on the same edge the hold limit is reached.
        cyc(); cyc(); cyc();
        done = 4'b0010;
        cyc();
        done = '0;
        check("same_edge_grant", int'(grant), 0);
        check("same_edge_preempt", int'(preempt), 0);

        // Owner 2, non-owner done, then reset mid-grant.
        req = 4'b0100;
        cyc();
        check("own2_grant", int'(grant), 4'b0100);
        done = 4'b0001;
        cyc();
        done = '0;
        check("nonowner_done", int'(grant), 4'b0100);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_grant", int'(grant), 0);
        check("midrst_ptr", int'(ptr), 0);
        check("midrst_preempt", int'(preempt), 0);

        // Mixed directed patterns; correctness comes from the per-cycle model compare.
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 8; j++) begin
                req  = pat_req[j];
                done = pat_done[j];
                cyc();
            end
        end
        req  = '0;
        done = '0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
Sequential owner of the round-robin pointer for a shared single-owner resource, such as a bus or a memory port, used by up to INPUTS requesters. It picks a winner with the existing combinational round_robin_arbiter core, driving its `state` input from an internal pointer. It then holds the grant across a multi-cycle transaction and releases it when the owner finishes, drops its request, or hits a hold-time limit. On every release it advances the pointer so that service stays fair.

Parameters:
INPUTS, 4, number of requesters; must be >= 2; need not be a power of two.
MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 = unlimited.
CNT_W, $clog2(MAX_HOLD+1) (minimum 1), width of the hold counter; derived, do not override.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
req  input  INPUTS  request vector; bit i = requester i wants the resource.
done  input  INPUTS  bit i = requester i ends its transaction this cycle; honoured only for the current owner.
grant  output  INPUTS  registered one-hot grant; all zero when no owner.
grant_valid  output  1  registered; 1 while any grant bit is set.
grant_idx  output  $clog2(INPUTS)  registered index of the owner; 0 when grant_valid=0.
preempt  output  1  one-cycle registered pulse marking a forced release on MAX_HOLD.
ptr  output  $clog2(INPUTS)  current round-robin pointer, i.e. the highest-priority index at the next arbitration.

Behaviour:
- Reset, sampled at the rising edge when rst=1:
  - grant=0, grant_valid=0, grant_idx=0, preempt=0, ptr=0.
  - Hold counter=0, FSM=IDLE.
  - rst has priority over every other event, including mid-grant; the grant drops the cycle after the reset edge.
- FSM has two states, IDLE and OWNED.
- IDLE:
  - Selection rule: the lowest index i >= ptr with req[i]=1; if there is none, the lowest index with req[i]=1.
  - If req != 0 at an edge: register the selected one-hot grant, grant_idx, grant_valid=1, hold counter=1, go to OWNED.
  - Grant latency is 1 cycle from the sampled request.
  - If req == 0: stay in IDLE; outputs stay zero.
- OWNED (owner o = grant_idx). Release conditions are evaluated at each edge:
  - (a) done[o]=1.
  - (b) req[o]=0.
  - (c) MAX_HOLD != 0 and hold counter == MAX_HOLD.
- Release action, when any condition holds:
  - Clear grant, grant_valid and grant_idx; go to IDLE.
  - ptr <= (o == INPUTS-1) ? 0 : o+1. Wrap-around is explicit and must not use modulo of a power of two.
  - preempt <= 1 only if (c) holds and neither (a) nor (b) holds; otherwise preempt <= 0.
- No release: hold grant; hold counter increments, saturating at MAX_HOLD; preempt <= 0.
- There is always at least one IDLE cycle between owners. Minimum handoff: release edge N, grant=0 during cycle N+1, new grant visible from cycle N+2.
- done bits of non-owners are ignored in every state; done in IDLE is ignored.
- Other requesters changing req during OWNED have no effect until the next IDLE evaluation.
- preempt is otherwise 0; it is high exactly in the cycle following the forced-release edge, coincident with grant=0.
- The hold counter never exceeds MAX_HOLD. With MAX_HOLD=0 the counter is unused and (c) never fires.
- ptr changes only on a release. It is never changed by arbitration in IDLE.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111 -> grant=0, grant_valid=0, ptr=0, preempt=0. Release rst -> grant=4'b0001 one cycle later.
- Rotation: req=4'b1111 held; each owner asserts done for 1 cycle after its 2nd grant cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001. ptr wraps 3->0 after owner 3.
- Skipping and wrap: ptr=2 (after owner 1 releases), req=4'b0011 -> grant=4'b0001 and ptr becomes 1 after release. Then req=4'b1001 -> grant=4'b1000.
- Timeout, MAX_HOLD=4: req=4'b0010 held, done=0 -> grant=0010 for exactly 4 cycles, then grant=0 with preempt=1 for 1 cycle. Next, grant=0010 regrants.
- Same-edge priority: done[o] asserted on the cycle the counter reaches MAX_HOLD -> release with preempt=0.
- Non-owner done and mid-grant reset:
  - With owner 2, pulse done=4'b0001 -> grant stays 0100.
  - Then assert rst -> grant=0 and ptr=0 the next cycle, with no preempt pulse.
